pos_bcd_sequencer: RTL and testbench
====================================

POS_BCD_SEQUENCER -- requirements
Module: pos_bcd_sequencer

Interface
REQ-001 The block SHALL have no parameters; widths and limits SHALL come from pos_bcd_pkg constants.
REQ-002 The block SHALL have these ports, one per line:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a conversion of x_pos/y_pos; sampled in IDLE only.
- x_pos  in  10  cursor x cell position, binary.
- y_pos  in  7  cursor y cell position, binary.
- busy  out  1  high while a conversion is in progress (states LOAD_X..SHIFT_Y).
- done  out  1  one-cycle pulse when the digit outputs update.
- x_ones, x_tens, x_huns  out  4 each  registered x decimal digits.
- y_ones, y_tens  out  4 each  registered y decimal digits.

Function
REQ-003 The block SHALL be an FSM with states IDLE, LOAD_X, SHIFT_X, LOAD_Y, SHIFT_Y, DONE.
REQ-004 In IDLE with start=1, the block SHALL snapshot x_pos and y_pos, then go to LOAD_X on the next cycle.
REQ-005 LOAD_X SHALL last 1 cycle and SHALL load the x snapshot into the shift core with the BCD field cleared.
REQ-006 SHIFT_X SHALL last exactly 10 cycles; each cycle SHALL add 3 to any BCD nibble >=5, then shift left by 1 (double-dabble).
REQ-007 LOAD_Y SHALL last 1 cycle, SHALL hold the x BCD result internally, and SHALL load the y snapshot.
REQ-008 SHIFT_Y SHALL last exactly 7 cycles using the same shift rule.
REQ-009 DONE SHALL last 1 cycle, SHALL update all five digit outputs together and assert done, then return to IDLE.
REQ-010 Digit outputs SHALL change only in DONE or on reset, so a partial result is never visible.
REQ-011 Latency SHALL be fixed: if start is sampled in cycle 0, done=1 and the new digits SHALL be visible in cycle 20.
REQ-012 start while busy=1 or in DONE SHALL be ignored; it is not queued.
REQ-013 Changes on x_pos/y_pos after the snapshot SHALL NOT affect the conversion in progress.
REQ-014 If the x snapshot is >999, all three x digits SHALL be 4'hF; if the y snapshot is >99, both y digits SHALL be 4'hF.
REQ-015 The out-of-range case SHALL keep the normal 20-cycle timing.
REQ-016 y_huns is not produced; a y BCD hundreds nibble of 1 SHALL be treated as out of range per REQ-014.
REQ-017 busy and done SHALL never be high in the same cycle.

Reset
REQ-018 reset=1 SHALL force IDLE, busy=0, done=0, and all digit outputs to 4'hF on the next edge, aborting any conversion.
REQ-019 An aborted conversion SHALL NOT produce done.
REQ-020 reset SHALL take priority over start in the same cycle.

Configuration
REQ-021 With POS_BCD_CHANGE_DETECT_EN defined, IDLE SHALL also start a conversion when x_pos or y_pos differs from the last snapshot, or on the first IDLE cycle after reset.
REQ-022 Without POS_BCD_CHANGE_DETECT_EN, only start SHALL begin a conversion, and the comparison logic SHALL be absent.

Structure
REQ-023 pos_bcd_pkg SHALL hold:
- the state enum;
- X_BITS=10, Y_BITS=7;
- X_SHIFTS=10, Y_SHIFTS=7;
- X_MAX=999, Y_MAX=99;
- DIGIT_BLANK=4'hF.
REQ-024 The shift/add-3 datapath SHALL be one sub-module, bcd_shift_core (10-bit binary in, 12-bit BCD out, load/shift controls), shared by the x and y phases.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then start with x=319, y=47 -> done in cycle 20; digits x=3,1,9 and y=4,7; busy high in cycles 1-19.
- x=999, y=99 -> 9,9,9 / 9,9. x=1000, y=100 -> F,F,F / F,F, done still in cycle 20.
- x=0, y=0 -> all digits 0.
- start with x=12, y=5, then at cycle 4 start again with x=800 -> only one done; digits 0,1,2 / 0,5.
- reset asserted in cycle 8 of a conversion -> busy=0, digits F, no done; a following start with x=7, y=3 -> 0,0,7 / 0,3.
- With POS_BCD_CHANGE_DETECT_EN: x_pos changes 5->6 in IDLE with start=0 -> done 20 cycles later, x_ones=6. Without the macro: no done.

Source files
------------

// File: rtl/pos_bcd_pkg.sv
// Shared constants, state encoding and nibble helper for the cursor-position BCD sequencer.
// Optional feature macro: POS_BCD_CHANGE_DETECT_EN (auto-start on position change).
package pos_bcd_pkg;

  localparam int X_BITS   = 10;
  localparam int Y_BITS   = 7;
  localparam int X_SHIFTS = 10;
  localparam int Y_SHIFTS = 7;
  localparam int X_MAX    = 999;
  localparam int Y_MAX    = 99;

  localparam int BIN_BITS = 10;
  localparam int BCD_BITS = 12;
  localparam int CNT_BITS = 4;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_X  = 3'd1,
    SHIFT_X = 3'd2,
    LOAD_Y  = 3'd3,
    SHIFT_Y = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Double-dabble correction applied to one decimal nibble before each shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/bcd_shift_core.sv
// Binary-to-BCD shift/add-3 datapath; one load or one shift step per cycle.
// Shared between the x and y phases of pos_bcd_sequencer.
module bcd_shift_core
  import pos_bcd_pkg::*;
(
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [BIN_BITS-1:0] bin_i,
  output logic [BCD_BITS-1:0] bcd_o,
  output logic [BCD_BITS-1:0] bcd_shifted_o
);

  logic [BIN_BITS-1:0] bin_q, bin_d;
  logic [BCD_BITS-1:0] bcd_q, bcd_d;
  logic [BCD_BITS-1:0] bcd_adj;

  generate
    for (genvar gi = 0; gi < BCD_BITS / 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = add3(bcd_q[gi*4 +: 4]);
    end
  endgenerate

  // Result of the step that would happen this cycle, so callers can capture it on the last shift.
  assign bcd_shifted_o = {bcd_adj[BCD_BITS-2:0], bin_q[BIN_BITS-1]};
  assign bcd_o         = bcd_q;

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    if (load_i) begin
      bin_d = bin_i;
      bcd_d = '0;
    end else if (shift_i) begin
      bin_d = {bin_q[BIN_BITS-2:0], 1'b0};
      bcd_d = bcd_shifted_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

endmodule

// File: rtl/pos_bcd_sequencer.sv
// Converts a cursor cell position (x, y) to decimal digits with a fixed 20-cycle latency.
// Define POS_BCD_CHANGE_DETECT_EN to also start a conversion whenever the position changes.
module pos_bcd_sequencer
  import pos_bcd_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [X_BITS-1:0] x_pos,
  input  logic [Y_BITS-1:0] y_pos,
  output logic              busy,
  output logic              done,
  output logic [3:0]        x_ones,
  output logic [3:0]        x_tens,
  output logic [3:0]        x_huns,
  output logic [3:0]        y_ones,
  output logic [3:0]        y_tens
);

  state_e state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [X_BITS-1:0]   x_snap_q, x_snap_d;
  logic [Y_BITS-1:0]   y_snap_q, y_snap_d;
  logic [BCD_BITS-1:0] x_bcd_q, x_bcd_d;
  logic [3:0] x_ones_q, x_tens_q, x_huns_q, y_ones_q, y_tens_q;

  logic                core_load;
  logic                core_shift;
  logic [BIN_BITS-1:0] core_bin;
  logic [BCD_BITS-1:0] core_bcd;
  logic [BCD_BITS-1:0] core_bcd_shifted;
  logic                digit_upd;
  logic                trigger;
  logic                x_oor;
  logic                y_oor;

`ifdef POS_BCD_CHANGE_DETECT_EN
  logic first_q, first_d;

  assign trigger = start | first_q | (x_pos != x_snap_q) | (y_pos != y_snap_q);

  always_comb begin
    first_d = first_q;
    if (state_q == IDLE && trigger) begin
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      first_q <= 1'b1;
    end else begin
      first_q <= first_d;
    end
  end
`else
  assign trigger = start;
`endif

  bcd_shift_core u_core (
    .clk_i         (clock),
    .srst_i        (reset),
    .load_i        (core_load),
    .shift_i       (core_shift),
    .bin_i         (core_bin),
    .bcd_o         (core_bcd),
    .bcd_shifted_o (core_bcd_shifted)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_snap_d   = x_snap_q;
    y_snap_d   = y_snap_q;
    x_bcd_d    = x_bcd_q;
    core_load  = 1'b0;
    core_shift = 1'b0;
    core_bin   = x_snap_q;
    digit_upd  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          x_snap_d = x_pos;
          y_snap_d = y_pos;
          state_d  = LOAD_X;
        end
      end
      LOAD_X: begin
        busy      = 1'b1;
        core_load = 1'b1;
        core_bin  = x_snap_q;
        cnt_d     = '0;
        state_d   = SHIFT_X;
      end
      SHIFT_X: begin
        busy       = 1'b1;
        core_shift = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_BITS'(X_SHIFTS - 1)) begin
          state_d = LOAD_Y;
        end
      end
      LOAD_Y: begin
        busy      = 1'b1;
        x_bcd_d   = core_bcd;
        core_load = 1'b1;
        // y is MSB-aligned so that Y_SHIFTS steps consume exactly its bits.
        core_bin  = {y_snap_q, {(BIN_BITS - Y_BITS){1'b0}}};
        cnt_d     = '0;
        state_d   = SHIFT_Y;
      end
      SHIFT_Y: begin
        busy       = 1'b1;
        core_shift = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_BITS'(Y_SHIFTS - 1)) begin
          digit_upd = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign x_oor = (x_snap_q > X_BITS'(X_MAX));
  assign y_oor = (core_bcd_shifted[11:8] != 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_snap_q <= '0;
      y_snap_q <= '0;
      x_bcd_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_snap_q <= x_snap_d;
      y_snap_q <= y_snap_d;
      x_bcd_q  <= x_bcd_d;
    end
  end

  // All five digits load together on the final shift edge, so they appear in DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_ones_q <= DIGIT_BLANK;
      x_tens_q <= DIGIT_BLANK;
      x_huns_q <= DIGIT_BLANK;
      y_ones_q <= DIGIT_BLANK;
      y_tens_q <= DIGIT_BLANK;
    end else if (digit_upd) begin
      x_ones_q <= x_oor ? DIGIT_BLANK : x_bcd_q[3:0];
      x_tens_q <= x_oor ? DIGIT_BLANK : x_bcd_q[7:4];
      x_huns_q <= x_oor ? DIGIT_BLANK : x_bcd_q[11:8];
      y_ones_q <= y_oor ? DIGIT_BLANK : core_bcd_shifted[3:0];
      y_tens_q <= y_oor ? DIGIT_BLANK : core_bcd_shifted[7:4];
    end
  end

  assign x_ones = x_ones_q;
  assign x_tens = x_tens_q;
  assign x_huns = x_huns_q;
  assign y_ones = y_ones_q;
  assign y_tens = y_tens_q;

endmodule

// File: tb/tb_pos_bcd_sequencer.sv
// Self-checking bench: cycle-count reference model plus directed and random stimulus.
// Build with POS_BCD_CHANGE_DETECT_EN to exercise the auto-start variant.
module tb_pos_bcd_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] x_pos;
  logic [6:0] y_pos;
  logic       busy;
  logic       done;
  logic [3:0] x_ones, x_tens, x_huns, y_ones, y_tens;

  always #5 clock = ~clock;

  pos_bcd_sequencer dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .x_pos  (x_pos),
    .y_pos  (y_pos),
    .busy   (busy),
    .done   (done),
    .x_ones (x_ones),
    .x_tens (x_tens),
    .x_huns (x_huns),
    .y_ones (y_ones),
    .y_tens (y_tens)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_k is the cycle index since the accepted request (0 = idle, 20 = done cycle).
  int         m_k = 0;
  bit         m_first = 1'b1;
  bit         m_trig;
  int         m_xs = 0;
  int         m_ys = 0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [3:0] m_dig [5];

  always @(posedge clock) begin
    if (reset) begin
      m_k = 0;
      m_first = 1'b1;
      m_xs = 0;
      m_ys = 0;
      for (int i = 0; i < 5; i++) m_dig[i] = 4'hF;
    end else if (m_k == 0) begin
      m_trig = start;
`ifdef POS_BCD_CHANGE_DETECT_EN
      m_trig = m_trig || m_first || (int'(x_pos) != m_xs) || (int'(y_pos) != m_ys);
`endif
      if (m_trig) begin
        m_xs = int'(x_pos);
        m_ys = int'(y_pos);
        m_first = 1'b0;
        m_k = 1;
      end
    end else if (m_k < 20) begin
      m_k++;
      if (m_k == 20) begin
        if (m_xs > 999) begin
          m_dig[0] = 4'hF; m_dig[1] = 4'hF; m_dig[2] = 4'hF;
        end else begin
          m_dig[0] = 4'(m_xs / 100);
          m_dig[1] = 4'((m_xs / 10) % 10);
          m_dig[2] = 4'(m_xs % 10);
        end
        if (m_ys > 99) begin
          m_dig[3] = 4'hF; m_dig[4] = 4'hF;
        end else begin
          m_dig[3] = 4'(m_ys / 10);
          m_dig[4] = 4'(m_ys % 10);
        end
      end
    end else begin
      m_k = 0;
    end
    m_busy = (m_k >= 1 && m_k <= 19);
    m_done = (m_k == 20);
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("busy",   32'(busy),   32'(m_busy));
      chk("done",   32'(done),   32'(m_done));
      chk("x_huns", 32'(x_huns), 32'(m_dig[0]));
      chk("x_tens", 32'(x_tens), 32'(m_dig[1]));
      chk("x_ones", 32'(x_ones), 32'(m_dig[2]));
      chk("y_tens", 32'(y_tens), 32'(m_dig[3]));
      chk("y_ones", 32'(y_ones), 32'(m_dig[4]));
      chk("busy_and_done", 32'(busy & done), 32'(0));
    end
  end

  task automatic settle();
    int run = 0;
    int n = 0;
    start = 1'b0;
    while (run < 2 && n < 200) begin
      @(negedge clock);
      n++;
      if (!busy && !done) run++;
      else run = 0;
    end
    chk("settle_idle", 32'(run >= 2), 32'(1));
  endtask

  task automatic convert(input int x, input int y, input logic [3:0] eh, input logic [3:0] et,
                         input logic [3:0] eo, input logic [3:0] eyt, input logic [3:0] eyo);
    int n;
    int busy_n = 0;
    reset = 1'b0;
    x_pos = 10'(x);
    y_pos = 7'(y);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (n < 30) begin
      if (done) break;
      if (busy) busy_n++;
      @(negedge clock);
      n++;
    end
    chk("done_cycle",  32'(n), 32'(20));
    chk("busy_cycles", 32'(busy_n), 32'(19));
    chk("lit_x_huns", 32'(x_huns), 32'(eh));
    chk("lit_x_tens", 32'(x_tens), 32'(et));
    chk("lit_x_ones", 32'(x_ones), 32'(eo));
    chk("lit_y_tens", 32'(y_tens), 32'(eyt));
    chk("lit_y_ones", 32'(y_ones), 32'(eyo));
    @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    int n_done;
    logic [3:0] cd_ones;

    reset = 1'b1;
    start = 1'b0;
    x_pos = '0;
    y_pos = '0;
    check_en = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy",   32'(busy),   32'(0));
    chk("rst_x_ones", 32'(x_ones), 32'(4'hF));
    chk("rst_y_tens", 32'(y_tens), 32'(4'hF));

    convert(319, 47, 4'd3, 4'd1, 4'd9, 4'd4, 4'd7);
    settle();
    convert(999, 99, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    settle();
    convert(1000, 100, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    settle();
    convert(0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    settle();

    // Second start during a conversion must be dropped.
    x_pos = 10'd12; y_pos = 7'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    x_pos = 10'd800; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 22; i++) begin
      if (done) begin
        dcount++;
        chk("ovl_x_huns", 32'(x_huns), 32'(0));
        chk("ovl_x_tens", 32'(x_tens), 32'(1));
        chk("ovl_x_ones", 32'(x_ones), 32'(2));
        chk("ovl_y_tens", 32'(y_tens), 32'(0));
        chk("ovl_y_ones", 32'(y_ones), 32'(5));
      end
      @(negedge clock);
    end
    chk("ovl_done_count", 32'(dcount), 32'(1));
    settle();

    // Reset in cycle 8 aborts the conversion.
    x_pos = 10'd500; y_pos = 7'd50; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy",   32'(busy),   32'(0));
    chk("abort_done",   32'(done),   32'(0));
    chk("abort_x_huns", 32'(x_huns), 32'(4'hF));
    chk("abort_y_ones", 32'(y_ones), 32'(4'hF));
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'(0));
    settle();
    convert(7, 3, 4'd0, 4'd0, 4'd7, 4'd0, 4'd3);
    settle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        x_pos = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
        y_pos = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(95, 127)) : 7'($urandom_range(0, 127));
      end
      @(negedge clock);
    end
    reset = 1'b0;
    settle();

    // Position change while idle, start low.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    x_pos = 10'd5;
    y_pos = 7'd0;
    settle();
    x_pos = 10'd6;
    n_done = 0;
    cd_ones = 4'h0;
    dcount = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (done) begin
        dcount++;
        if (n_done == 0) begin
          n_done = n;
          cd_ones = x_ones;
        end
      end
    end
`ifdef POS_BCD_CHANGE_DETECT_EN
    chk("cd_done_cycle", 32'(n_done), 32'(20));
    chk("cd_x_ones",     32'(cd_ones), 32'(6));
`else
    chk("cd_no_done", 32'(dcount), 32'(0));
`endif

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
